// File: rtl/alu_exec_unit.sv
// Integer execute stage: computes one issued op per cycle and queues the result in a
// small FIFO whose head drives the common data bus.
module alu_exec_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              rs_valid,
  input  logic [5:0]        rs_op_id,
  input  logic [31:0]       rs_pc,
  input  logic [31:0]       rs_rs1,
  input  logic [31:0]       rs_rs2,
  input  logic [31:0]       rs_imm,
  input  logic [ROB_W-1:0]  rs_rob_id,
  output logic              alu_almost_full,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_id,
  output logic [31:0]       cdb_value,
  output logic              cdb_is_ctrl,
  output logic [31:0]       cdb_target_pc,
  input  logic              cdb_grant,
  output logic              overflow_err
);

  // Op id encoding shared with the reservation station.
  localparam logic [5:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_ADD   = 6'd11, OP_SUB   = 6'd12;
  localparam logic [5:0] OP_SLL   = 6'd13, OP_SLT   = 6'd14, OP_SLTU  = 6'd15, OP_XOR   = 6'd16;
  localparam logic [5:0] OP_SRL   = 6'd17, OP_SRA   = 6'd18, OP_OR    = 6'd19, OP_AND   = 6'd20;
  localparam logic [5:0] OP_ADDI  = 6'd21, OP_SLTI  = 6'd22, OP_SLTIU = 6'd23, OP_XORI  = 6'd24;
  localparam logic [5:0] OP_ORI   = 6'd25, OP_ANDI  = 6'd26, OP_SLLI  = 6'd27, OP_SRLI  = 6'd28;
  localparam logic [5:0] OP_SRAI  = 6'd29;

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ROB_W + 1 + 32 + 32;

  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_sum;
  logic        taken;
  logic [31:0] res_value;
  logic        res_ctrl;
  logic [31:0] res_target;

  assign shamt       = op2[4:0];
  assign pc_plus4    = rs_pc + 32'd4;
  assign pc_plus_imm = rs_pc + rs_imm;
  assign jalr_sum    = rs_rs1 + rs_imm;

  always_comb begin
    op2 = rs_rs2;
    case (rs_op_id)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI:
        op2 = rs_imm;
      default: ;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (rs_op_id)
      OP_BEQ:  taken = (rs_rs1 == rs_rs2);
      OP_BNE:  taken = (rs_rs1 != rs_rs2);
      OP_BLT:  taken = ($signed(rs_rs1) <  $signed(rs_rs2));
      OP_BGE:  taken = ($signed(rs_rs1) >= $signed(rs_rs2));
      OP_BLTU: taken = (rs_rs1 <  rs_rs2);
      OP_BGEU: taken = (rs_rs1 >= rs_rs2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res_value  = '0;
    res_ctrl   = 1'b0;
    res_target = '0;
    case (rs_op_id)
      OP_ADD, OP_ADDI:   res_value = rs_rs1 + op2;
      OP_SUB:            res_value = rs_rs1 - rs_rs2;
      OP_AND, OP_ANDI:   res_value = rs_rs1 & op2;
      OP_OR,  OP_ORI:    res_value = rs_rs1 | op2;
      OP_XOR, OP_XORI:   res_value = rs_rs1 ^ op2;
      OP_SLL, OP_SLLI:   res_value = rs_rs1 << shamt;
      OP_SRL, OP_SRLI:   res_value = rs_rs1 >> shamt;
      OP_SRA, OP_SRAI:   res_value = $unsigned($signed(rs_rs1) >>> shamt);
      OP_SLT, OP_SLTI:   res_value = {31'b0, $signed(rs_rs1) < $signed(op2)};
      OP_SLTU, OP_SLTIU: res_value = {31'b0, rs_rs1 < op2};
      OP_LUI:            res_value = rs_imm;
      OP_AUIPC:          res_value = pc_plus_imm;
      OP_JAL: begin
        res_value  = pc_plus4;
        res_ctrl   = 1'b1;
        res_target = pc_plus_imm;
      end
      OP_JALR: begin
        res_value  = pc_plus4;
        res_ctrl   = 1'b1;
        res_target = jalr_sum & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_value  = {31'b0, taken};
        res_ctrl   = 1'b1;
        res_target = taken ? pc_plus_imm : pc_plus4;
      end
      default: ;
    endcase
  end

  // Result FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] head_entry;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push_req, push, pop, full, drop;

  assign entry_d  = {rs_rob_id, res_ctrl, res_value, res_target};
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_req = rdy & ~rollback & rs_valid;
  assign pop      = rdy & ~rollback & cdb_valid & cdb_grant;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (rollback) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (rdy) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= entry_d;
  end

  assign head_entry      = mem_q[head_q];
  assign cdb_valid       = (count_q != '0);
  assign cdb_rob_id      = cdb_valid ? head_entry[ENTRY_W-1 -: ROB_W] : '0;
  assign cdb_is_ctrl     = cdb_valid & head_entry[64];
  assign cdb_value       = cdb_valid ? head_entry[63:32] : '0;
  assign cdb_target_pc   = cdb_valid ? head_entry[31:0] : '0;
  assign alu_almost_full = (count_q >= CNT_W'(FIFO_DEPTH - 1));
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors, a queue-based reference model checked every
// cycle, and literal expectations at the interesting points.
module tb_alu_exec_unit;

  localparam int DEPTH = 4;

  localparam logic [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4, BEQ = 5, BNE = 6, BLT = 7, BGE = 8;
  localparam logic [5:0] BLTU = 9, BGEU = 10, ADD = 11, SUB = 12, SLL = 13, SLT = 14, SLTU = 15;
  localparam logic [5:0] XOR = 16, SRL = 17, SRA = 18, OR = 19, AND = 20, ADDI = 21, SLTI = 22;
  localparam logic [5:0] SLTIU = 23, XORI = 24, ORI = 25, ANDI = 26, SLLI = 27, SRLI = 28, SRAI = 29;

  logic        clk, rst, rdy, rollback, rs_valid, cdb_grant;
  logic [5:0]  rs_op_id;
  logic [31:0] rs_pc, rs_rs1, rs_rs2, rs_imm;
  logic [3:0]  rs_rob_id;
  logic        alu_almost_full, cdb_valid, cdb_is_ctrl, overflow_err;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value, cdb_target_pc;

  alu_exec_unit #(.FIFO_DEPTH(DEPTH), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_valid(rs_valid),
    .rs_op_id(rs_op_id), .rs_pc(rs_pc), .rs_rs1(rs_rs1), .rs_rs2(rs_rs2), .rs_imm(rs_imm),
    .rs_rob_id(rs_rob_id), .alu_almost_full(alu_almost_full), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_is_ctrl(cdb_is_ctrl),
    .cdb_target_pc(cdb_target_pc), .cdb_grant(cdb_grant), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
    logic        ctrl;
    logic [31:0] target;
  } ent_t;

  // Reference: what each op must produce, straight from the ISA rules.
  function automatic ent_t calc(input logic [5:0] op, input logic [31:0] pc, a, b, imm,
                                input logic [3:0] rob);
    ent_t e;
    int sa, sb, si;
    logic [31:0] o2;
    bit is_br;
    bit tk;
    e = '0;
    e.rob = rob;
    o2 = (op inside {ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI}) ? imm : b;
    sa = a; sb = b; si = o2;
    is_br = 1'b1;
    case (op)
      BEQ:  tk = (a == b);
      BNE:  tk = (a != b);
      BLT:  tk = (sa < sb);
      BGE:  tk = !(sa < sb);
      BLTU: tk = (a < b);
      BGEU: tk = !(a < b);
      default: begin tk = 1'b0; is_br = 1'b0; end
    endcase
    if (is_br) begin
      e.value = tk ? 32'd1 : 32'd0;
      e.ctrl = 1'b1;
      e.target = tk ? pc + imm : pc + 32'd4;
    end else begin
      case (op)
        ADD, ADDI:   e.value = a + o2;
        SUB:         e.value = a - b;
        AND, ANDI:   e.value = a & o2;
        OR, ORI:     e.value = a | o2;
        XOR, XORI:   e.value = a ^ o2;
        SLL, SLLI:   e.value = a << o2[4:0];
        SRL, SRLI:   e.value = a >> o2[4:0];
        SRA, SRAI:   e.value = sa >>> o2[4:0];
        SLT, SLTI:   e.value = (sa < si) ? 32'd1 : 32'd0;
        SLTU, SLTIU: e.value = (a < o2) ? 32'd1 : 32'd0;
        LUI:         e.value = imm;
        AUIPC:       e.value = pc + imm;
        JAL:  begin e.value = pc + 4; e.ctrl = 1'b1; e.target = pc + imm; end
        JALR: begin e.value = pc + 4; e.ctrl = 1'b1; e.target = (a + imm) & 32'hFFFF_FFFE; end
        default: ;
      endcase
    end
    return e;
  endfunction

  ent_t mq[$];
  bit   m_ovf;
  bit   m_pop;
  int   m_before;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        mq.delete();
      end else begin
        m_before = mq.size();
        m_pop = cdb_grant && (m_before > 0);
        if (m_pop) void'(mq.pop_front());
        if (rs_valid) begin
          if (m_before < DEPTH || m_pop)
            mq.push_back(calc(rs_op_id, rs_pc, rs_rs1, rs_rs2, rs_imm, rs_rob_id));
          else
            m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mq.size() > 0) begin
      chk("m_valid",  cdb_valid,     32'd1);
      chk("m_rob",    cdb_rob_id,    mq[0].rob);
      chk("m_value",  cdb_value,     mq[0].value);
      chk("m_ctrl",   cdb_is_ctrl,   mq[0].ctrl);
      chk("m_target", cdb_target_pc, mq[0].target);
    end else begin
      chk("m_valid",  cdb_valid,     32'd0);
      chk("m_rob",    cdb_rob_id,    32'd0);
      chk("m_value",  cdb_value,     32'd0);
      chk("m_ctrl",   cdb_is_ctrl,   32'd0);
      chk("m_target", cdb_target_pc, 32'd0);
    end
    chk("m_almost_full", alu_almost_full, (mq.size() >= DEPTH - 1) ? 32'd1 : 32'd0);
    chk("m_overflow",    overflow_err,    {31'b0, m_ovf});
  end

  task automatic drive(input logic [5:0] op, input logic [31:0] pc, a, b, imm,
                       input logic [3:0] rob, input logic v, g, rb, rd);
    rs_op_id = op; rs_pc = pc; rs_rs1 = a; rs_rs2 = b; rs_imm = imm; rs_rob_id = rob;
    rs_valid = v; cdb_grant = g; rollback = rb; rdy = rd;
    @(negedge clk);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] pc, a, b, imm,
                       input logic [3:0] rob, input logic g);
    drive(op, pc, a, b, imm, rob, 1'b1, g, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic g, input int n);
    repeat (n) drive(6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, g, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; rs_valid = 1'b0; cdb_grant = 1'b0;
    rs_op_id = '0; rs_pc = '0; rs_rs1 = '0; rs_rs2 = '0; rs_imm = '0; rs_rob_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", cdb_valid, 32'd0);
    chk("rst_af", alu_almost_full, 32'd0);
    chk("rst_ovf", overflow_err, 32'd0);
    rst = 1'b1;
    idle(1'b0, 1);

    // Single ADD with wrap-around
    issue(ADD, 32'h0, 32'd7, 32'hFFFF_FFFF, 32'h0, 4'd3, 1'b1);
    $display("ADD rob=3 -> valid=%0d rob=%0d value=%h", cdb_valid, cdb_rob_id, cdb_value);
    chk("add_valid", cdb_valid, 32'd1);
    chk("add_rob", cdb_rob_id, 32'd3);
    chk("add_value", cdb_value, 32'd6);
    idle(1'b1, 1);
    chk("add_empty", cdb_valid, 32'd0);

    issue(SRA, 32'h0, 32'h8000_0000, 32'd33, 32'h0, 4'd5, 1'b1);
    $display("SRA -> value=%h", cdb_value);
    chk("sra_value", cdb_value, 32'hC000_0000);
    issue(SLTU, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h0, 4'd6, 1'b1);
    $display("SLTU -> value=%h rob=%0d", cdb_value, cdb_rob_id);
    chk("sltu_value", cdb_value, 32'd1);
    chk("sltu_rob", cdb_rob_id, 32'd6);

    issue(BNE, 32'h100, 32'd1, 32'd2, 32'hFFFF_FFF8, 4'd7, 1'b1);
    $display("BNE -> value=%h ctrl=%0d target=%h", cdb_value, cdb_is_ctrl, cdb_target_pc);
    chk("bne_value", cdb_value, 32'd1);
    chk("bne_ctrl", cdb_is_ctrl, 32'd1);
    chk("bne_target", cdb_target_pc, 32'hF8);
    issue(JALR, 32'h40, 32'h203, 32'h0, 32'h0, 4'd8, 1'b1);
    $display("JALR -> value=%h target=%h", cdb_value, cdb_target_pc);
    chk("jalr_value", cdb_value, 32'h44);
    chk("jalr_target", cdb_target_pc, 32'h202);
    idle(1'b1, 1);

    // Directed op table, checked by the model
    issue(ADDI,  32'h0,    32'd10,        32'd0,        32'hFFFF_FFFF, 4'd1, 1'b1);
    issue(SUB,   32'h0,    32'd3,         32'd5,        32'h0,         4'd2, 1'b1);
    issue(AND,   32'h0,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        4'd3, 1'b1);
    issue(ORI,   32'h0,    32'h0000_00F0, 32'h0,        32'h0F,        4'd4, 1'b1);
    issue(XORI,  32'h0,    32'hAAAA_AAAA, 32'h0,        32'hFFFF_FFFF, 4'd5, 1'b1);
    issue(SLL,   32'h0,    32'h1,         32'd36,       32'h0,         4'd6, 1'b1);
    issue(SRLI,  32'h0,    32'h8000_0000, 32'h0,        32'd31,        4'd7, 1'b1);
    issue(SRAI,  32'h0,    32'h7000_0000, 32'h0,        32'd4,         4'd8, 1'b1);
    issue(SLT,   32'h0,    32'hFFFF_FFFF, 32'd1,        32'h0,         4'd9, 1'b1);
    issue(SLTI,  32'h0,    32'd5,         32'h0,        32'hFFFF_FFFF, 4'd10, 1'b1);
    issue(SLTIU, 32'h0,    32'd5,         32'h0,        32'hFFFF_FFFF, 4'd11, 1'b1);
    issue(LUI,   32'h0,    32'h0,         32'h0,        32'h1234_5000, 4'd12, 1'b1);
    issue(AUIPC, 32'h1000, 32'h0,         32'h0,        32'h2000,      4'd13, 1'b1);
    issue(JAL,   32'h80,   32'h0,         32'h0,        32'hFFFF_FF80, 4'd14, 1'b1);
    issue(BEQ,   32'h200,  32'd9,         32'd9,        32'h10,        4'd15, 1'b1);
    issue(BLT,   32'h200,  32'hFFFF_FFFF, 32'd0,        32'h20,        4'd0, 1'b1);
    issue(BGE,   32'h200,  32'hFFFF_FFFF, 32'd0,        32'h20,        4'd1, 1'b1);
    issue(BLTU,  32'h200,  32'hFFFF_FFFF, 32'd0,        32'h20,        4'd2, 1'b1);
    issue(BGEU,  32'h200,  32'hFFFF_FFFF, 32'd0,        32'h20,        4'd3, 1'b1);
    issue(6'd63, 32'h300,  32'd1,         32'd2,        32'd3,         4'd4, 1'b1);
    idle(1'b1, 2);

    // Fill without grant, overflow on the fifth issue, then drain in order
    for (int i = 0; i < 4; i++) begin
      issue(ADD, 32'h0, i, 32'd0, 32'h0, 4'(i), 1'b0);
      $display("fill %0d -> almost_full=%0d", i, alu_almost_full);
      chk("fill_af", alu_almost_full, (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("fill_no_ovf", overflow_err, 32'd0);
    issue(ADD, 32'h0, 32'd4, 32'd0, 32'h0, 4'd4, 1'b0);
    $display("5th issue -> overflow_err=%0d", overflow_err);
    chk("ovf_set", overflow_err, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_rob", cdb_rob_id, i);
      idle(1'b1, 1);
    end
    chk("drain_empty", cdb_valid, 32'd0);

    // Asynchronous reset in the middle of a cycle with a full FIFO
    for (int i = 0; i < 4; i++) issue(ADD, 32'h0, i, 32'd1, 32'h0, 4'(8 + i), 1'b0);
    rs_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    $display("async reset -> valid=%0d ovf=%0d af=%0d", cdb_valid, overflow_err, alu_almost_full);
    chk("arst_valid", cdb_valid, 32'd0);
    chk("arst_ovf", overflow_err, 32'd0);
    chk("arst_af", alu_almost_full, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full FIFO with simultaneous issue and grant
    for (int i = 1; i <= 4; i++) issue(ADD, 32'h0, i, 32'd2, 32'h0, 4'(i), 1'b0);
    issue(SUB, 32'h0, 32'd9, 32'd2, 32'h0, 4'd5, 1'b1);
    $display("full push+pop -> ovf=%0d af=%0d head=%0d", overflow_err, alu_almost_full, cdb_rob_id);
    chk("pp_ovf", overflow_err, 32'd0);
    chk("pp_af", alu_almost_full, 32'd1);
    chk("pp_head", cdb_rob_id, 32'd2);
    for (int j = 0; j < 4; j++) begin
      chk("pp_drain", cdb_rob_id, 2 + j);
      idle(1'b1, 1);
    end
    chk("pp_empty", cdb_valid, 32'd0);

    // Rollback with a same-cycle issue
    issue(ADD, 32'h0, 32'd1, 32'd1, 32'h0, 4'd6, 1'b0);
    issue(ADD, 32'h0, 32'd2, 32'd2, 32'h0, 4'd7, 1'b0);
    drive(ADD, 32'h0, 32'd3, 32'd3, 32'h0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    $display("rollback -> valid=%0d af=%0d", cdb_valid, alu_almost_full);
    chk("rb_valid", cdb_valid, 32'd0);
    chk("rb_af", alu_almost_full, 32'd0);

    // rdy=0 freezes everything
    issue(ADD, 32'h0, 32'd4, 32'd4, 32'h0, 4'd10, 1'b0);
    issue(ADD, 32'h0, 32'd5, 32'd5, 32'h0, 4'd11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(ADD, 32'h0, 32'd6, 32'd6, 32'h0, 4'd12, 1'b1, 1'b1, 1'b1, 1'b0);
      $display("rdy=0 cycle %0d -> valid=%0d head=%0d", k, cdb_valid, cdb_rob_id);
      chk("frz_valid", cdb_valid, 32'd1);
      chk("frz_head", cdb_rob_id, 32'd10);
    end
    idle(1'b1, 3);
    chk("frz_empty", cdb_valid, 32'd0);

    // Mixed random traffic, checked by the model
    for (int r = 0; r < 80; r++) begin
      drive(6'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) != 0));
    end
    idle(1'b1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
